// File: rtl/tt_um_chandrakanth_tdm_demux.sv
// rtl/tt_um_chandrakanth_tdm_demux.sv - strobe-clocked TDM receiver splitting one serial link into two nibble channels
module tt_um_chandrakanth_tdm_demux #(
  parameter int CH_BITS = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int DATA_BITS = 2 * CH_BITS;

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t               r_state, w_state_n;
  logic [3:0]           r_cnt, w_cnt_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [DATA_BITS-1:0] r_data, w_data_n;
  logic                 r_frame_stb, w_frame_stb_n;
  logic                 r_par_err, r_sync_err;
  logic                 w_par_set, w_sync_set;
  logic [2:0]           r_s1, r_s2;
  logic                 r_s3_bstb;
  logic                 w_bit_evt, w_sdata, w_fsync, w_err_clr;
  logic                 w_unused;

  assign w_unused  = &{1'b0, ena, ui_in[7:3], uio_in[7:1]};
  assign w_sdata   = r_s2[0];
  assign w_fsync   = r_s2[1];
  assign w_bit_evt = r_s2[2] & ~r_s3_bstb;
  assign w_err_clr = uio_in[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3_bstb <= 1'b0;
    end else begin
      r_s1      <= ui_in[2:0];
      r_s2      <= r_s1;
      r_s3_bstb <= r_s2[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_frame_stb <= 1'b0;
      r_par_err   <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_shift     <= w_shift_n;
      r_data      <= w_data_n;
      r_frame_stb <= w_frame_stb_n;
      // A set in the same cycle as a clear must win.
      r_par_err   <= w_par_set  | (r_par_err  & ~w_err_clr);
      r_sync_err  <= w_sync_set | (r_sync_err & ~w_err_clr);
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_shift_n     = r_shift;
    w_data_n      = r_data;
    w_frame_stb_n = 1'b0;
    w_par_set     = 1'b0;
    w_sync_set    = 1'b0;
    if (w_bit_evt) begin
      case (r_state)
        HUNT: begin
          if (w_fsync) begin
            w_shift_n    = '0;
            w_shift_n[0] = w_sdata;
            w_cnt_n      = 4'd1;
            w_state_n    = RECV;
          end
        end
        RECV: begin
          if (w_fsync) begin
            // Unexpected sync mid-frame: restart on this bit as bit 0.
            w_sync_set   = 1'b1;
            w_shift_n    = '0;
            w_shift_n[0] = w_sdata;
            w_cnt_n      = 4'd1;
          end else if (r_cnt < 4'(DATA_BITS)) begin
            w_shift_n[r_cnt[2:0]] = w_sdata;
            w_cnt_n               = r_cnt + 4'd1;
          end else begin
            if ((^r_shift ^ w_sdata) == 1'b0) begin
              w_data_n      = r_shift;
              w_frame_stb_n = 1'b1;
            end else begin
              w_par_set = 1'b1;
            end
            w_state_n = HUNT;
            w_cnt_n   = '0;
          end
        end
        default: w_state_n = HUNT;
      endcase
    end
  end

  assign uo_out  = r_data;
  assign uio_out = {(r_state == RECV), r_sync_err, r_par_err, r_frame_stb, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_chandrakanth_tdm_demux.sv
// tb/tb_tt_um_chandrakanth_tdm_demux.sv - scoreboard bench for the TDM demux top
module tb_tt_um_chandrakanth_tdm_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt = 0;
  logic prev_stb = 1'b0;
  logic [7:0] exp_q[$];

  tt_um_chandrakanth_tdm_demux dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: each frame_stb pops the next expected word.
  always @(negedge clk) begin
    if (rst_n && uio_out[4] === 1'b1) begin
      stb_cnt++;
      check("stb_width", {7'b0, prev_stb}, 8'h00);
      if (exp_q.size() == 0) begin
        check("unexpected_stb", 8'h01, 8'h00);
      end else begin
        check("sb_data", uo_out, exp_q.pop_front());
      end
    end
    prev_stb = uio_out[4];
  end

  task automatic send_bit(input logic sd, input logic fs);
    @(negedge clk);
    ui_in[2:0] = {1'b1, fs, sd};
    repeat (2) @(negedge clk);
    ui_in[2:0] = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  // Sends bits lo..hi-1 of frame d; bad flips the parity bit.
  task automatic send_frame(input logic [7:0] d, input logic bad, input int lo, input int hi);
    logic b;
    for (int i = lo; i < hi; i++) begin
      if (i < 8) b = d[i];
      else begin
        b = (^d) ^ bad;
        if (!bad) exp_q.push_back(d);
      end
      send_bit(b, i == 0);
      if (i == 0) check("locked_in_frame", {7'b0, uio_out[7]}, 8'h01);
      if (i == 8) check("locked_after", {7'b0, uio_out[7]}, 8'h00);
    end
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
  endtask

  initial begin
    int s0;
    #1;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    s0 = stb_cnt;
    send_frame(8'hA5, 1'b0, 0, 9);
    check("good_uo", uo_out, 8'hA5);
    check("good_stb_count", 8'(stb_cnt - s0), 8'h01);
    check("good_no_err", uio_out & 8'h60, 8'h00);

    s0 = stb_cnt;
    send_frame(8'hA5, 1'b1, 0, 9);
    check("bad_uo_held", uo_out, 8'hA5);
    check("bad_no_stb", 8'(stb_cnt - s0), 8'h00);
    check("bad_par_err", {7'b0, uio_out[5]}, 8'h01);
    repeat (3) @(negedge clk);
    check("par_err_sticky", {7'b0, uio_out[5]}, 8'h01);
    pulse_clr();
    check("par_err_clr", {7'b0, uio_out[5]}, 8'h00);

    send_frame(8'hA5, 1'b0, 0, 5);
    check("partial_locked", {7'b0, uio_out[7]}, 8'h01);
    send_frame(8'h3C, 1'b0, 0, 9);
    check("resync_sync_err", {7'b0, uio_out[6]}, 8'h01);
    check("resync_uo", uo_out, 8'h3C);
    pulse_clr();
    check("sync_err_clr", uio_out & 8'h60, 8'h00);

    @(negedge clk);
    ui_in[2:0] = 3'b111;
    repeat (10) @(negedge clk);
    ui_in[2:0] = 3'b000;
    repeat (2) @(negedge clk);
    check("held_locked", {7'b0, uio_out[7]}, 8'h01);
    send_frame(8'h37, 1'b0, 1, 9);
    check("held_uo", uo_out, 8'h37);
    check("held_no_err", uio_out & 8'h60, 8'h00);

    send_frame(8'hA5, 1'b0, 0, 4);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_uo", uo_out, 8'h00);
    check("midrst_uio", uio_out, 8'h00);
    check("midrst_oe", uio_oe, 8'hF0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'hA5, 1'b0, 0, 9);
    check("post_rst_uo", uo_out, 8'hA5);
    check("post_rst_no_err", uio_out & 8'h60, 8'h00);

    repeat (4) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
